// File: rtl/dmem_pkg.sv
// Shared defaults and FSM state encoding for the data memory controller.
// Optional word parity is enabled by defining DMEM_PARITY_EN.
package dmem_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DEPTH      = 64;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single write port / single read port RAM, synchronous write and read.
// No reset on storage; contents are defined by the controller's clear sweep.
module dmem_array #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: clear sweep after reset, then write/read service with 1-cycle reads.
// Defining DMEM_PARITY_EN adds a stored even-parity bit and the parity_err output.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] data_mem_address,
    input  logic [DATA_W-1:0] reg_Data_2,
    output logic [DATA_W-1:0] mem_Data_in,
    output logic              rd_valid,
    output logic              busy
`ifdef DMEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef DMEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] data_hold_q;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic              arr_re;
    logic [WORD_W-1:0] arr_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rd_valid_q  <= 1'b0;
            data_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= rd_valid_d;
            if (rd_valid_q) begin
                data_hold_q <= arr_rdata[DATA_W-1:0];
            end
        end
    end

    // Write wins over a simultaneous read; the read is simply dropped.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rd_valid_d = 1'b0;
        busy       = 1'b0;
        arr_we     = 1'b0;
        arr_re     = 1'b0;
        arr_waddr  = data_mem_address;
`ifdef DMEM_PARITY_EN
        arr_wdata  = {^reg_Data_2, reg_Data_2};
`else
        arr_wdata  = reg_Data_2;
`endif
        unique case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                arr_we    = 1'b1;
                arr_waddr = clr_cnt_q;
                arr_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE, RESP: begin
                state_d = IDLE;
                if (mem_wr) begin
                    arr_we = 1'b1;
                end else if (mem_rd) begin
                    arr_re     = 1'b1;
                    rd_valid_d = 1'b1;
                    state_d    = RESP;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    dmem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (data_mem_address),
        .rdata (arr_rdata)
    );

    // The RAM read register has no reset, so the held copy supplies the idle/reset value.
    assign mem_Data_in = rd_valid_q ? arr_rdata[DATA_W-1:0] : data_hold_q;
    assign rd_valid    = rd_valid_q;

`ifdef DMEM_PARITY_EN
    assign parity_err = rd_valid_q & (^arr_rdata);
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: clear sweep, reads/writes, collisions, reset restart.
// The parity step is compiled only when DMEM_PARITY_EN is defined.
module tb_data_memory_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] data_mem_address;
    logic [DW-1:0] reg_Data_2;
    logic [DW-1:0] mem_Data_in;
    logic          rd_valid;
    logic          busy;
`ifdef DMEM_PARITY_EN
    logic          parity_err;
`endif

    int total = 0;
    int bad   = 0;

    data_memory_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .mem_rd           (mem_rd),
        .mem_wr           (mem_wr),
        .data_mem_address (data_mem_address),
        .reg_Data_2       (reg_Data_2),
        .mem_Data_in      (mem_Data_in),
        .rd_valid         (rd_valid),
        .busy             (busy)
`ifdef DMEM_PARITY_EN
        ,
        .parity_err       (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_rd           = rd;
        mem_wr           = wr;
        data_mem_address = a;
        reg_Data_2       = d;
    endtask

    initial begin
        int n;
        logic seen_valid;

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        #3;
        check("reset_busy", 32'(busy), 32'h1);
        check("reset_valid", 32'(rd_valid), 32'h0);
        check("reset_data", 32'(mem_Data_in), 32'h0);

        tick();
        rst = 1'b0;
        // hold a read request through the clear: it must be ignored
        drive(1'b1, 1'b0, 6'd63, '0);
        n = 0;
        seen_valid = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            if (rd_valid !== 1'b0) seen_valid = 1'b1;
            tick();
            n++;
        end
        check("clear_busy_cycles", 32'(n), 32'd64);
        check("clear_no_valid", 32'(seen_valid), 32'h0);

        tick();
        check("rd63_valid", 32'(rd_valid), 32'h1);
        check("rd63_data", 32'(mem_Data_in), 32'h0000);

        drive(1'b0, 1'b1, 6'd5, 16'hBEEF);
        tick();
        check("wr5_valid", 32'(rd_valid), 32'h0);
        drive(1'b1, 1'b0, 6'd5, '0);
        tick();
        check("rd5_valid", 32'(rd_valid), 32'h1);
        check("rd5_data", 32'(mem_Data_in), 32'hBEEF);
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("idle_valid_drop", 32'(rd_valid), 32'h0);
        check("idle_data_hold", 32'(mem_Data_in), 32'hBEEF);

        drive(1'b0, 1'b1, 6'd1, 16'h0011); tick();
        drive(1'b0, 1'b1, 6'd2, 16'h0022); tick();
        drive(1'b0, 1'b1, 6'd3, 16'h0033); tick();
        drive(1'b1, 1'b0, 6'd1, '0); tick();
        check("b2b1_valid", 32'(rd_valid), 32'h1);
        check("b2b1_data", 32'(mem_Data_in), 32'h0011);
        drive(1'b1, 1'b0, 6'd2, '0); tick();
        check("b2b2_valid", 32'(rd_valid), 32'h1);
        check("b2b2_data", 32'(mem_Data_in), 32'h0022);
        drive(1'b1, 1'b0, 6'd3, '0); tick();
        check("b2b3_valid", 32'(rd_valid), 32'h1);
        check("b2b3_data", 32'(mem_Data_in), 32'h0033);

        drive(1'b1, 1'b1, 6'd7, 16'h1234); tick();
        check("rdwr_valid", 32'(rd_valid), 32'h0);
        check("rdwr_hold", 32'(mem_Data_in), 32'h0033);
        drive(1'b1, 1'b0, 6'd7, '0); tick();
        check("rd7_valid", 32'(rd_valid), 32'h1);
        check("rd7_data", 32'(mem_Data_in), 32'h1234);

        drive(1'b0, 1'b1, 6'd0, 16'h00FF); tick();
        drive(1'b0, 1'b1, 6'd63, 16'hA5A5); tick();
        drive(1'b1, 1'b0, 6'd0, '0); tick();
        check("rd0_data", 32'(mem_Data_in), 32'h00FF);
        drive(1'b1, 1'b0, 6'd63, '0); tick();
        check("rd63b_data", 32'(mem_Data_in), 32'hA5A5);
        drive(1'b0, 1'b0, '0, '0);

        rst = 1'b1;
        #2;
        check("rst2_busy", 32'(busy), 32'h1);
        check("rst2_data", 32'(mem_Data_in), 32'h0);
        check("rst2_valid", 32'(rd_valid), 32'h0);
        tick();
        rst = 1'b0;
        // write held during the whole clear must never land
        drive(1'b0, 1'b1, 6'd5, 16'hAAAA);
        for (int i = 0; i < 30; i++) tick();
        check("pre_abort_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #2;
        check("abort_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("restart_busy_cycles", 32'(n), 32'd64);
        drive(1'b1, 1'b0, 6'd5, '0); tick();
        check("ignored_wr5_data", 32'(mem_Data_in), 32'h0000);
        check("ignored_wr5_valid", 32'(rd_valid), 32'h1);
        drive(1'b1, 1'b0, 6'd1, '0); tick();
        check("recleared1_data", 32'(mem_Data_in), 32'h0000);
        drive(1'b0, 1'b0, '0, '0);
        tick();

`ifdef DMEM_PARITY_EN
        drive(1'b0, 1'b1, 6'd9, 16'h0001); tick();
        drive(1'b1, 1'b0, 6'd9, '0); tick();
        check("par_ok", 32'(parity_err), 32'h0);
        drive(1'b0, 1'b0, '0, '0); tick();
        u_dut.u_array.mem[9][DW] = ~u_dut.u_array.mem[9][DW];
        drive(1'b1, 1'b0, 6'd9, '0); tick();
        check("par_err", 32'(parity_err), 32'h1);
        check("par_valid", 32'(rd_valid), 32'h1);
        drive(1'b0, 1'b0, '0, '0); tick();
        check("par_err_drop", 32'(parity_err), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
